// File: rtl/uart_rx_fifo_if.sv
// Consumer-side stream of the UART receiver: FIFO head data with valid/ready.
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rxData;
  logic                 rxParityErr;
  logic                 rxValid;
  logic                 rxReady;

  modport master (output rxData, output rxParityErr, output rxValid, input rxReady);
  modport slave  (input rxData, input rxParityErr, input rxValid, output rxReady);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable data/parity/stop bits, error detection and a show-ahead
// FIFO drained over a valid/ready stream.
// Optional: define UART_RX_MAJORITY_EN for 2-of-3 majority voting around each bit centre.
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic                        rx,
  uart_rx_fifo_if.master              rxIf,
  output logic                        frameErr,
  output logic                        overrun,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifoCount
);
  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned Q = BAUD_DIV / 8;
`else
  localparam int unsigned Q = 0;
`endif
  // Decision points: start bit at its centre (+Q), later bits one full bit period apart.
  localparam int unsigned START_DEC = BAUD_DIV / 2 - 1 + Q;
  localparam int unsigned BIT_DEC   = BAUD_DIV - 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e             stateQ, stateD;
  logic [CNT_W-1:0]   cntQ, cntD, decPt;
  logic [3:0]         bitCntQ, bitCntD;
  logic [DATA_BITS-1:0] shQ, shD;
  logic               perrQ, perrD;
  logic               rxMeta, rxS, decide, bitVal;
  logic               frameDone, frameBad;
  logic               frameErrQ, overrunQ;

  logic [DATA_BITS:0] mem [FIFO_DEPTH];
  logic [DATA_BITS:0] head;
  logic [AW-1:0]      wrPtrQ, rdPtrQ;
  logic [AW:0]        countQ;
  logic               valid, full, push, pop;

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxS    <= rxMeta;
    end
  end

  assign decPt  = (stateQ == StStart) ? CNT_W'(START_DEC) : CNT_W'(BIT_DEC);
  assign decide = (cntQ == decPt);

`ifdef UART_RX_MAJORITY_EN
  logic s0Q, s1Q;
  // Capture the two early votes at -Q and 0 relative to the bit centre.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s0Q <= 1'b1;
      s1Q <= 1'b1;
    end else begin
      if (cntQ == decPt - CNT_W'(2 * Q)) s0Q <= rxS;
      if (cntQ == decPt - CNT_W'(Q))     s1Q <= rxS;
    end
  end
  assign bitVal = (s0Q & s1Q) | (s0Q & rxS) | (s1Q & rxS);
`else
  assign bitVal = rxS;
`endif

  // Receive FSM state and datapath registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateQ    <= StIdle;
      cntQ      <= '0;
      bitCntQ   <= '0;
      shQ       <= '0;
      perrQ     <= 1'b0;
      frameErrQ <= 1'b0;
      overrunQ  <= 1'b0;
    end else begin
      stateQ    <= stateD;
      cntQ      <= cntD;
      bitCntQ   <= bitCntD;
      shQ       <= shD;
      perrQ     <= perrD;
      frameErrQ <= frameBad;
      overrunQ  <= frameDone & full & ~pop;
    end
  end

  // Next-state logic; a frame resolves on its last stop decision and returns straight to idle.
  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ + 1'b1;
    bitCntD   = bitCntQ;
    shD       = shQ;
    perrD     = perrQ;
    frameDone = 1'b0;
    frameBad  = 1'b0;
    unique case (stateQ)
      StIdle: begin
        cntD = '0;
        if (!rxS) stateD = StStart;
      end
      StStart: begin
        if (decide) begin
          cntD    = '0;
          bitCntD = '0;
          perrD   = 1'b0;
          stateD  = bitVal ? StIdle : StData;
        end
      end
      StData: begin
        if (decide) begin
          cntD = '0;
          shD  = {bitVal, shQ[DATA_BITS-1:1]};
          if (bitCntQ == 4'(DATA_BITS - 1)) begin
            bitCntD = '0;
            stateD  = (PARITY != 0) ? StParity : StStop;
          end else begin
            bitCntD = bitCntQ + 4'd1;
          end
        end
      end
      StParity: begin
        if (decide) begin
          cntD   = '0;
          perrD  = ((^shQ) ^ bitVal) != logic'(PARITY == 1);
          stateD = StStop;
        end
      end
      StStop: begin
        if (decide) begin
          cntD = '0;
          if (!bitVal) begin
            frameBad = 1'b1;
            stateD   = StIdle;
          end else if (bitCntQ == 4'(STOP_BITS - 1)) begin
            frameDone = 1'b1;
            stateD    = StIdle;
          end else begin
            bitCntD = bitCntQ + 4'd1;
          end
        end
      end
      default: stateD = StIdle;
    endcase
  end

  assign valid = (countQ != '0);
  assign full  = (countQ == (AW + 1)'(FIFO_DEPTH));
  assign pop   = valid & rxIf.rxReady;
  // A full FIFO still accepts a frame when the head is popped in the same cycle.
  assign push  = frameDone & (~full | pop);

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (push) wrPtrQ <= wrPtrQ + 1'b1;
      if (pop)  rdPtrQ <= rdPtrQ + 1'b1;
      case ({push, pop})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
    end
  end

  // FIFO storage: {parityErr, data} per entry.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtrQ] <= {perrQ, shQ};
  end

  // Head is gated by valid so stale storage never shows on the outputs.
  assign head             = mem[rdPtrQ];
  assign rxIf.rxValid     = valid;
  assign rxIf.rxData      = valid ? head[DATA_BITS-1:0] : '0;
  assign rxIf.rxParityErr = valid & head[DATA_BITS];
  assign frameErr         = frameErrQ;
  assign overrun          = overrunQ;
  assign busy             = (stateQ != StIdle);
  assign fifoCount        = countQ;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: lane 0 is an 8N1 receiver, lane 1 is 8E2. Both at BAUD_DIV = 10.
module tb_uart_rx_fifo;
`ifdef UART_RX_MAJORITY_EN
  localparam int Q = 1;
`else
  localparam int Q = 0;
`endif
  // Cycles from driving the start bit to the first idle cycle after resolve:
  // 2 sync + 1 idle detect + 5 to start centre = 8, then 10 per remaining bit.
  localparam int LatN = 8 + 10 * 9 + Q;
  localparam int LatE = 8 + 10 * 11 + Q;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  logic       rxL[2];
  logic       readyL[2];
  logic       validL[2], perrL[2], feL[2], ovL[2], busyL[2];
  logic [7:0] dataL[2];
  logic [2:0] cntL[2];

  uart_rx_fifo_if #(.DATA_BITS(8)) ifN ();
  uart_rx_fifo_if #(.DATA_BITS(8)) ifE ();
  assign ifN.rxReady = readyL[0];
  assign ifE.rxReady = readyL[1];
  assign validL[0] = ifN.rxValid;
  assign validL[1] = ifE.rxValid;
  assign perrL[0]  = ifN.rxParityErr;
  assign perrL[1]  = ifE.rxParityErr;
  assign dataL[0]  = ifN.rxData;
  assign dataL[1]  = ifE.rxData;

  uart_rx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dutN (
    .clk(clk), .rstN(rstN), .rx(rxL[0]), .rxIf(ifN), .frameErr(feL[0]),
    .overrun(ovL[0]), .busy(busyL[0]), .fifoCount(cntL[0]));

  uart_rx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) dutE (
    .clk(clk), .rstN(rstN), .rx(rxL[1]), .rxIf(ifE), .frameErr(feL[1]),
    .overrun(ovL[1]), .busy(busyL[1]), .fifoCount(cntL[1]));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int feCnt[2] = '{0, 0};
  int ovCnt[2] = '{0, 0};
  int busyCyc[2] = '{0, 0};
  int startL[2] = '{0, 0};
  int busyFall[2] = '{-1, -1};
  int validRise[2] = '{-1, -1};
  logic busyPrev[2] = '{1'b0, 1'b0};
  logic validPrev[2] = '{1'b0, 1'b0};
  logic [8:0] popN[$];
  logic [8:0] popE[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe pulses, busy/valid edges (first after each frame start) and accepted entries.
  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (feL[l]) feCnt[l] <= feCnt[l] + 1;
      if (ovL[l]) ovCnt[l] <= ovCnt[l] + 1;
      if (busyL[l]) busyCyc[l] <= busyCyc[l] + 1;
      if (busyPrev[l] && !busyL[l] && busyFall[l] < startL[l]) busyFall[l] <= cyc;
      if (!validPrev[l] && validL[l] && validRise[l] < startL[l]) validRise[l] <= cyc;
      busyPrev[l]  <= busyL[l];
      validPrev[l] <= validL[l];
    end
    if (validL[0] && readyL[0]) popN.push_back({perrL[0], dataL[0]});
    if (validL[1] && readyL[1]) popE.push_back({perrL[1], dataL[1]});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame, 10 clocks per bit; glitchAt inverts rx for one clock at that offset.
  task automatic sendFrame(input int lane, input logic [7:0] data, input bit flipPar,
                           input bit stopLow, input int glitchAt);
    logic [11:0] fr;
    int n;
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = data;
    if (lane == 0) begin
      fr[9] = ~stopLow;
      n = 10;
    end else begin
      fr[9]  = (^data) ^ flipPar;
      fr[10] = 1'b1;
      fr[11] = ~stopLow;
      n = 12;
    end
    startL[lane] = cyc;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < 10; c++) begin
        rxL[lane] = fr[b] ^ ((b * 10 + c) == glitchAt);
        @(posedge clk);
        #1;
      end
    end
    rxL[lane] = 1'b1;
  endtask

  task automatic popOne(input int lane);
    readyL[lane] = 1'b1;
    @(posedge clk);
    #1;
    readyL[lane] = 1'b0;
  endtask

  // Drain with random back-pressure; a FIFO that never empties is a failure.
  task automatic drain(input int lane);
    int k;
    k = 0;
    while (validL[lane] && k < 300) begin
      readyL[lane] = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      k++;
    end
    readyL[lane] = 1'b0;
    check("drain_empty", 32'(validL[lane]), 0);
  endtask

  typedef struct {
    int lane;
    logic [7:0] data;
    bit flip;
    bit stopLow;
    bit expFe;
    logic [7:0] expData;
    bit expPerr;
  } vec_t;

  vec_t vecs[8];
  vec_t v;
  logic [8:0] expQ[$];
  logic [8:0] exp4[4];
  int fe0, ov0, b0, lat, nFr, gap;
  logic [7:0] rd;
  bit rf, rs;

  initial begin
    #600_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[1] = '{1, 8'h07, 1'b0, 1'b0, 1'b0, 8'h07, 1'b0};
    vecs[2] = '{1, 8'h07, 1'b1, 1'b0, 1'b0, 8'h07, 1'b1};
    vecs[3] = '{0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{0, 8'h11, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0};
    vecs[5] = '{1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{1, 8'h80, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1};
    vecs[7] = '{1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0};
    rxL[0] = 1'b1;
    rxL[1] = 1'b1;
    readyL[0] = 1'b0;
    readyL[1] = 1'b0;
    idle(3);
    for (int l = 0; l < 2; l++) begin
      check("rst_valid", 32'(validL[l]), 0);
      check("rst_data", 32'(dataL[l]), 0);
      check("rst_count", 32'(cntL[l]), 0);
      check("rst_busy", 32'(busyL[l]), 0);
      check("rst_pulses", {30'd0, feL[l], ovL[l]}, 0);
    end
    rstN = 1'b1;
    idle(5);

    // Single frames: timing, data, parity flag, frame error.
    foreach (vecs[i]) begin
      v = vecs[i];
      lat = (v.lane == 0) ? LatN : LatE;
      fe0 = feCnt[v.lane];
      ov0 = ovCnt[v.lane];
      sendFrame(v.lane, v.data, v.flip, v.stopLow, -1);
      idle(15);
      check("vec_busy_fall", busyFall[v.lane] - startL[v.lane], lat);
      check("vec_frame_err", feCnt[v.lane] - fe0, 32'(v.expFe));
      check("vec_overrun", ovCnt[v.lane] - ov0, 0);
      check("vec_count", 32'(cntL[v.lane]), v.expFe ? 0 : 1);
      if (!v.expFe) begin
        check("vec_valid_rise", validRise[v.lane] - startL[v.lane], lat);
        check("vec_data", 32'(dataL[v.lane]), 32'(v.expData));
        check("vec_perr", 32'(perrL[v.lane]), 32'(v.expPerr));
        popOne(v.lane);
        check("vec_pop_count", 32'(cntL[v.lane]), 0);
      end
    end

    // Five back-to-back frames into a depth-4 FIFO: the fifth overruns.
    fe0 = feCnt[0];
    ov0 = ovCnt[0];
    for (int d = 1; d <= 5; d++) sendFrame(0, 8'(d), 1'b0, 1'b0, -1);
    idle(5);
    check("ovr_count", 32'(cntL[0]), 4);
    check("ovr_pulses", ovCnt[0] - ov0, 1);
    check("ovr_no_fe", feCnt[0] - fe0, 0);

    // Full FIFO with a pop in the resolve cycle: push and pop both happen.
    ov0 = ovCnt[0];
    popN.delete();
    fork
      sendFrame(0, 8'h06, 1'b0, 1'b0, -1);
      begin
        #1;
        repeat (LatN - 1) @(posedge clk);
        #1;
        readyL[0] = 1'b1;
        @(posedge clk);
        #1;
        readyL[0] = 1'b0;
      end
    join
    idle(5);
    check("fullpp_count", 32'(cntL[0]), 4);
    check("fullpp_no_ovr", ovCnt[0] - ov0, 0);
    check("fullpp_popped", popN.size() > 0 ? 32'(popN[0]) : 32'hDEAD, 32'h001);
    popN.delete();
    drain(0);
    exp4 = '{9'h002, 9'h003, 9'h004, 9'h006};
    check("fullpp_drain_n", popN.size(), 4);
    for (int k = 0; k < 4 && k < popN.size(); k++) check("fullpp_order", popN[k], exp4[k]);

    // Short low glitch on idle line is rejected.
    b0 = busyCyc[0];
    fe0 = feCnt[0];
    ov0 = ovCnt[0];
    rxL[0] = 1'b0;
    idle(3);
    rxL[0] = 1'b1;
    idle(20);
    checkRange("glitch_busy_len", busyCyc[0] - b0, 4, 8);
    check("glitch_count", 32'(cntL[0]), 0);
    check("glitch_pulses", (feCnt[0] - fe0) + (ovCnt[0] - ov0), 0);
`ifdef UART_RX_MAJORITY_EN
    sendFrame(0, 8'h55, 1'b0, 1'b0, 35);
    idle(5);
    check("maj_glitch_data", 32'(dataL[0]), 32'h55);
    popOne(0);
`endif

    // Asynchronous reset mid-frame with two entries queued.
    sendFrame(0, 8'h21, 1'b0, 1'b0, -1);
    sendFrame(0, 8'h42, 1'b0, 1'b0, -1);
    check("mid_pre_count", 32'(cntL[0]), 2);
    rxL[0] = 1'b0;
    idle(40);
    #2 rstN = 1'b0;
    #1;
    check("mid_rst_valid", 32'(validL[0]), 0);
    check("mid_rst_count", 32'(cntL[0]), 0);
    check("mid_rst_busy", 32'(busyL[0]), 0);
    check("mid_rst_data", {23'd0, perrL[0], dataL[0]}, 0);
    rxL[0] = 1'b1;
    idle(3);
    rstN = 1'b1;
    idle(5);
    sendFrame(0, 8'h99, 1'b0, 1'b0, -1);
    idle(5);
    check("post_rst_data", 32'(dataL[0]), 32'h99);
    check("post_rst_count", 32'(cntL[0]), 1);
    popOne(0);

    // Random bursts on the 8E2 lane against a queue model of the FIFO.
    for (int burst = 0; burst < 6; burst++) begin
      expQ.delete();
      popE.delete();
      fe0 = feCnt[1];
      ov0 = ovCnt[1];
      b0 = 0;
      lat = 0;
      nFr = $urandom_range(1, 6);
      for (int f = 0; f < nFr; f++) begin
        rd = 8'($urandom);
        rf = ($urandom_range(0, 3) == 0);
        rs = ($urandom_range(0, 5) == 0);
        if (rs) b0++;
        else if (expQ.size() < 4) expQ.push_back({rf, rd});
        else lat++;
        sendFrame(1, rd, rf, rs, -1);
        gap = rs ? 12 : $urandom_range(0, 3);
        if (gap > 0) idle(gap);
      end
      idle(15);
      check("rand_count", 32'(cntL[1]), expQ.size());
      check("rand_frame_err", feCnt[1] - fe0, b0);
      check("rand_overrun", ovCnt[1] - ov0, lat);
      drain(1);
      check("rand_drain_n", popE.size(), expQ.size());
      for (int k = 0; k < expQ.size() && k < popE.size(); k++)
        check("rand_entry", popE[k], expQ[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
